// File: rtl/ov5640_capture.sv
// OV5640 capture path: input sync, warm-up frame skip, beat-to-pixel packing and line checking.
// Define OV5640_CAPTURE_CROP_EN to add the crop_* ports and the crop window filter.
module ov5640_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int SKIP_FRAMES   = 10,
  parameter int VSYNC_POL     = 1
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            capture_en,
  input  logic                            cam_vsync,
  input  logic                            cam_href,
  input  logic [DATA_W-1:0]               cam_data,
`ifdef OV5640_CAPTURE_CROP_EN
  input  logic [11:0]                     crop_x0,
  input  logic [11:0]                     crop_y0,
  input  logic [11:0]                     crop_w,
  input  logic [11:0]                     crop_h,
`endif
  output logic                            pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
  output logic                            pix_sof,
  output logic                            pix_eol,
  output logic                            line_err,
  output logic [15:0]                     frame_cnt,
  output logic                            busy
);

  localparam int          PIX_W    = DATA_W * BYTES_PER_PIX;
  localparam logic        VS_ACT   = (VSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [1:0]  B_LAST   = 2'(BYTES_PER_PIX - 1);
  localparam logic [12:0] H_LIM    = 13'(H_ACTIVE);
  localparam logic [12:0] V_LIM    = 13'(V_ACTIVE);
  localparam logic [8:0]  SKIP_LIM = 9'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t             state_r;
  logic               vsync_r1, vsync_r2, href_r1, href_r2;
  logic [DATA_W-1:0]  data_r1;
  logic [PIX_W-1:0]   hold_r, pend_data_r;
  logic [1:0]         b_r;
  logic [11:0]        x_r, y_r;
  logic [7:0]         skip_cnt_r;
  logic               pend_valid_r, pend_sof_r, pend_eol_r, pend_err_r;

  logic               fs_s, fall_s, last_beat_s, in_win_s, sof_s, eol_s, bad_line_s;
  logic [PIX_W-1:0]   pixel_s;
  logic [11:0]        x_inc_s, y_inc_s;

`ifdef OV5640_CAPTURE_CROP_EN
  logic [11:0]        cx0_r, cy0_r, cw_r, ch_r;
  logic [12:0]        x_end_s, y_end_s;
`endif

  // Edge detection, packing view of the current beat and window/flag decode for the pixel at (x,y).
  always_comb begin
    fs_s        = (vsync_r2 == VS_ACT) && (vsync_r1 != VS_ACT);
    fall_s      = href_r2 && !href_r1;
    pixel_s     = PIX_W'({hold_r, data_r1});
    last_beat_s = (b_r == B_LAST);
    x_inc_s     = (x_r == 12'hFFF) ? x_r : x_r + 12'd1;
    y_inc_s     = (y_r == 12'hFFF) ? y_r : y_r + 12'd1;
    bad_line_s  = (b_r != 2'd0) || ({1'b0, x_r} != H_LIM);
`ifdef OV5640_CAPTURE_CROP_EN
    x_end_s     = {1'b0, cx0_r} + {1'b0, cw_r};
    y_end_s     = {1'b0, cy0_r} + {1'b0, ch_r};
    in_win_s    = ({1'b0, x_r} >= {1'b0, cx0_r}) && ({1'b0, x_r} < x_end_s) &&
                  ({1'b0, y_r} >= {1'b0, cy0_r}) && ({1'b0, y_r} < y_end_s) &&
                  ({1'b0, y_r} < V_LIM);
    sof_s       = (x_r == cx0_r) && (y_r == cy0_r);
    eol_s       = ({1'b0, x_r} == (x_end_s - 13'd1));
`else
    in_win_s    = ({1'b0, y_r} < V_LIM);
    sof_s       = (x_r == 12'd0) && (y_r == 12'd0);
    eol_s       = ({1'b0, x_r} == (H_LIM - 13'd1));
`endif
  end

  // Input sync, capture FSM, packing counters and the two-stage registered output path.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      vsync_r1     <= ~VS_ACT;
      vsync_r2     <= ~VS_ACT;
      href_r1      <= 1'b0;
      href_r2      <= 1'b0;
      data_r1      <= '0;
      hold_r       <= '0;
      b_r          <= 2'd0;
      x_r          <= 12'd0;
      y_r          <= 12'd0;
      skip_cnt_r   <= 8'd0;
      pend_valid_r <= 1'b0;
      pend_data_r  <= '0;
      pend_sof_r   <= 1'b0;
      pend_eol_r   <= 1'b0;
      pend_err_r   <= 1'b0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      line_err     <= 1'b0;
      frame_cnt    <= 16'd0;
      busy         <= 1'b0;
`ifdef OV5640_CAPTURE_CROP_EN
      cx0_r        <= 12'd0;
      cy0_r        <= 12'd0;
      cw_r         <= 12'd0;
      ch_r         <= 12'd0;
`endif
    end else begin
      vsync_r1     <= cam_vsync;
      vsync_r2     <= vsync_r1;
      href_r1      <= cam_href;
      href_r2      <= href_r1;
      data_r1      <= cam_data;
      pend_valid_r <= 1'b0;
      pend_sof_r   <= 1'b0;
      pend_eol_r   <= 1'b0;
      pend_err_r   <= 1'b0;
      pix_valid    <= pend_valid_r;
      pix_data     <= pend_data_r;
      pix_sof      <= pend_sof_r;
      pix_eol      <= pend_eol_r;
      line_err     <= pend_err_r;
      busy         <= (state_r != ST_IDLE);
      if (fs_s) begin
        // Frame start wins over any beat or line end in the same cycle.
        b_r <= 2'd0;
        x_r <= 12'd0;
        y_r <= 12'd0;
`ifdef OV5640_CAPTURE_CROP_EN
        cx0_r <= crop_x0;
        cy0_r <= crop_y0;
        cw_r  <= crop_w;
        ch_r  <= crop_h;
`endif
        case (state_r)
          ST_IDLE: begin
            skip_cnt_r <= 8'd0;
            if (capture_en) begin
              state_r <= (SKIP_FRAMES == 0) ? ST_ACTIVE : ST_SKIP;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            if (({1'b0, skip_cnt_r} + 9'd1) == SKIP_LIM) begin
              state_r <= capture_en ? ST_ACTIVE : ST_IDLE;
            end else begin
              skip_cnt_r <= skip_cnt_r + 8'd1;
            end
          end
          ST_ACTIVE: begin
            frame_cnt <= frame_cnt + 16'd1;
            state_r   <= capture_en ? ST_ACTIVE : ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r == ST_ACTIVE) begin
        if (href_r1) begin
          hold_r <= pixel_s;
          if (last_beat_s) begin
            b_r <= 2'd0;
            x_r <= x_inc_s;
            if (in_win_s) begin
              pend_valid_r <= 1'b1;
              pend_data_r  <= pixel_s;
              pend_sof_r   <= sof_s;
              pend_eol_r   <= eol_s;
            end
          end else begin
            b_r <= b_r + 2'd1;
          end
        end else if (fall_s) begin
          pend_err_r <= bad_line_s;
          b_r        <= 2'd0;
          x_r        <= 12'd0;
          y_r        <= y_inc_s;
        end
      end
    end
  end

endmodule
